// File: rtl/filter_select_if.sv
// filter_select_if: pushbutton inputs and filter-mode outputs of filter_select_fsm.
interface filter_select_if #(
    parameter int NUM_MODES = 4
);
    localparam int MW = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1;
    logic [3:0]    key;
    logic [MW-1:0] filter_type;
    logic          bypass;
    logic          mode_changed;
    modport master (output key, input filter_type, bypass, mode_changed);
    modport slave (input key, output filter_type, bypass, mode_changed);
endinterface

// File: rtl/filter_select_fsm.sv
// filter_select_fsm: debounced four-key selector stepping through filter modes with bypass and home.
// Each key runs sync -> debounce -> press edge; the press register feeds the mode update one cycle later.
module filter_select_fsm #(
    parameter int NUM_MODES       = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RESET_MODE      = 0
) (
    input logic          clk,
    input logic          reset,
    filter_select_if.slave bus
);
    localparam int MW = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1;
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [MW-1:0] LAST = MW'(NUM_MODES - 1);
    localparam logic [MW-1:0] HOME = MW'(RESET_MODE);
    localparam logic [MW-1:0] ONE  = MW'(1);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CONE = CW'(1);

    logic [3:0]    sync1, sync2, level, level_q, press;
    logic [CW-1:0] cnt [4];
    logic [MW-1:0] ft, ft_n, inc, dec;
    logic          bp, bp_n, home, flip, step;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= '1;
            sync2   <= '1;
            level   <= '1;
            level_q <= '1;
            press   <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            sync1   <= bus.key;
            sync2   <= sync1;
            level_q <= level;
            press   <= level_q & ~level;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CMAX) begin
                    level[i] <= sync2[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CONE;
                end
            end
        end
    end

    // home overrides bypass toggle, which overrides next/prev; next with prev cancels
    assign home = press[3];
    assign flip = ~home & press[2];
    assign step = ~home & ~press[2] & ~bp & (press[0] ^ press[1]);
    assign inc  = (ft == LAST) ? '0 : ft + ONE;
    assign dec  = (ft == '0) ? LAST : ft - ONE;
    assign ft_n = home ? HOME : step ? (press[0] ? inc : dec) : ft;
    assign bp_n = ~home & (bp ^ flip);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ft               <= HOME;
            bp               <= 1'b0;
            bus.mode_changed <= 1'b0;
        end else begin
            ft               <= ft_n;
            bp               <= bp_n;
            bus.mode_changed <= (ft_n != ft) | (bp_n != bp);
        end
    end

    assign bus.filter_type = ft;
    assign bus.bypass      = bp;
endmodule

// File: tb/tb_filter_select_fsm.sv
// tb_filter_select_fsm: scoreboard bench; each press queues its expected strobe, the monitor pops on mode_changed.
module tb_filter_select_fsm;
    localparam int NM = 5;
    localparam int DB = 4;
    localparam int LAT = DB + 4;

    typedef struct {
        int ft;
        int bp;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   m_ft = 0;
    int   m_bp = 0;
    exp_t sbq[$];

    filter_select_if #(.NUM_MODES(NM)) intf ();

    filter_select_fsm #(.NUM_MODES(NM), .DEBOUNCE_CYCLES(DB), .RESET_MODE(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (intf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && intf.mode_changed) begin
            if (sbq.size() == 0) begin
                check("spurious_strobe", 1, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("strobe_cycle", cyc, e.cyc);
                check("strobe_ft", int'(intf.filter_type), e.ft);
                check("strobe_bp", int'(intf.bypass), e.bp);
            end
        end
    end

    task automatic press(input logic [3:0] m, input int hold);
        int nft, nbp;
        @(negedge clk);
        intf.key = ~m;
        nft = m_ft;
        nbp = m_bp;
        if (m[3]) begin
            nft = 0;
            nbp = 0;
        end else if (m[2]) begin
            nbp = 1 - m_bp;
        end else if (m_bp == 0 && m[0] != m[1]) begin
            nft = m[0] ? (m_ft + 1) % NM : (m_ft + NM - 1) % NM;
        end
        if (nft != m_ft || nbp != m_bp) sbq.push_back('{nft, nbp, cyc + LAT});
        m_ft = nft;
        m_bp = nbp;
        repeat (hold) @(negedge clk);
        intf.key = '1;
        repeat (12) @(negedge clk);
        check("state_ft", int'(intf.filter_type), m_ft);
        check("state_bp", int'(intf.bypass), m_bp);
    endtask

    task automatic pulse0(input int n);
        @(negedge clk);
        intf.key = 4'b1110;
        repeat (n) @(negedge clk);
        intf.key = '1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        intf.key = '1;
        repeat (3) @(negedge clk);
        check("rst_ft", int'(intf.filter_type), 0);
        check("rst_bp", int'(intf.bypass), 0);
        check("rst_mc", int'(intf.mode_changed), 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        // seven next presses: 1,2,3,4,0,1,2; one long hold must not repeat
        press(4'b0001, 8);
        press(4'b0001, 40);
        for (int i = 0; i < 5; i++) press(4'b0001, 8);
        press(4'b1000, 8);
        press(4'b0010, 8);
        // bounces shorter than the debounce window
        pulse0(3);
        repeat (2) @(negedge clk);
        pulse0(3);
        repeat (12) @(negedge clk);
        check("bounce_ft", int'(intf.filter_type), m_ft);
        press(4'b0100, 8);
        press(4'b0001, 8);
        press(4'b0001, 8);
        press(4'b0100, 8);
        press(4'b0011, 8);
        press(4'b0010, 8);
        press(4'b0100, 8);
        check("pre_home_ft", int'(intf.filter_type), 3);
        check("pre_home_bp", int'(intf.bypass), 1);
        press(4'b1001, 8);
        press(4'b1000, 8);
        press(4'b0001, 8);
        press(4'b0001, 8);
        // reset lands mid-debounce; the held key registers once afterwards
        @(negedge clk);
        intf.key = 4'b1110;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_ft", int'(intf.filter_type), 0);
        check("midrst_bp", int'(intf.bypass), 0);
        check("midrst_mc", int'(intf.mode_changed), 0);
        @(negedge clk);
        reset = 1'b0;
        m_ft = 1;
        m_bp = 0;
        sbq.push_back('{1, 0, cyc + LAT});
        repeat (20) @(negedge clk);
        intf.key = '1;
        repeat (12) @(negedge clk);
        check("post_rst_ft", int'(intf.filter_type), m_ft);
        check("pending_strobes", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/filter_select_fsm.md
FILTER_SELECT_FSM -- requirements
Module: filter_select_fsm

Interface
REQ-001 Parameter NUM_MODES, default 4, number of selectable filter modes; legal range 2..16.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000, consecutive stable cycles needed to accept a key level (10 ms at 50 MHz); legal range >=1.
REQ-003 Parameter RESET_MODE, default 0, mode loaded on reset and on home press; legal range 0..NUM_MODES-1.
REQ-004 Derived width MW = max(1, ceil(log2(NUM_MODES))).
REQ-005 clk  input  1  system clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 key  input  4  raw pushbuttons, active-low, asynchronous to clk: key[0] next, key[1] prev, key[2] bypass toggle, key[3] home.
REQ-008 filter_type  output  MW  currently selected filter mode, registered.
REQ-009 bypass  output  1  1 = filter chain bypassed, registered.
REQ-010 mode_changed  output  1  single-cycle strobe when filter_type or bypass changes value.

Function
REQ-011 Each key bit SHALL pass through a 2-flop synchroniser before any other use.
REQ-012 Each key SHALL have an independent debouncer: counter increments while synchronised level differs from debounced level, clears to 0 on any cycle they match.
REQ-013 Debounced level SHALL take the synchronised value on the cycle the counter would reach DEBOUNCE_CYCLES; counter then clears.
REQ-014 A press event SHALL be a debounced 1->0 transition, one cycle wide; releases generate no event.
REQ-015 Latency raw key falling edge (stable thereafter) to filter_type/bypass update SHALL be exactly DEBOUNCE_CYCLES+3 clk cycles.
REQ-016 Event priority within one cycle: home > bypass toggle > next/prev.
REQ-017 home: filter_type <= RESET_MODE and bypass <= 0; other same-cycle events ignored.
REQ-018 bypass toggle: bypass <= ~bypass; same-cycle next/prev ignored.
REQ-019 next and prev in the same cycle SHALL cancel; no change.
REQ-020 next (bypass=0): filter_type <= filter_type+1, wrapping NUM_MODES-1 -> 0.
REQ-021 prev (bypass=0): filter_type <= filter_type-1, wrapping 0 -> NUM_MODES-1.
REQ-022 While bypass=1, next/prev SHALL be ignored; filter_type holds its value through bypass on and off.
REQ-023 filter_type SHALL never hold a value >= NUM_MODES.
REQ-024 mode_changed SHALL be 1 in exactly the cycle in which new filter_type/bypass values are first visible, only if at least one differs from its prior value (home while already at RESET_MODE with bypass=0 -> no strobe).
REQ-025 A key held continuously SHALL produce exactly one event; no auto-repeat.
REQ-026 Bounces shorter than DEBOUNCE_CYCLES SHALL produce no event.

Reset
REQ-027 While reset=1: filter_type=RESET_MODE, bypass=0, mode_changed=0, synchroniser and debounced levels=1 (released), all counters=0.
REQ-028 Reset asserted mid-debounce SHALL discard the partial count; a key still held at reset release SHALL register as one press after DEBOUNCE_CYCLES+3 cycles (debounced level restarts at released).

Verification (NUM_MODES=5, DEBOUNCE_CYCLES=4, RESET_MODE=0)
REQ-029 Reset, hold key[0] low -> filter_type 0->1 exactly 7 cycles after the sampled falling edge, mode_changed high that one cycle; six more presses -> 2,3,4,0,1,2.
REQ-030 From 0, one key[1] press -> filter_type=4 (wrap), mode_changed pulses once.
REQ-031 key[0] low 3 cycles, high 2, low 3, high -> no event; filter_type unchanged, mode_changed stays 0.
REQ-032 Press key[2] -> bypass=1; press key[0] twice -> filter_type unchanged, no strobe; press key[2] -> bypass=0, filter_type unchanged.
REQ-033 key[0] and key[1] pressed same cycle -> no change; key[3] with key[0] same cycle at mode 3, bypass=1 -> mode 0, bypass 0, one strobe.
REQ-034 Assert reset 2 cycles into a key[0] debounce while key stays low -> outputs at reset values; after release exactly one advance, 7 cycles after reset deasserts.
